// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues byte fetches to biu_top, buffers returned code bytes
// in a modulo-DEPTH FIFO and hands them to the EU; an EU flush discards everything and reloads IP.
module prefetch_queue #(
  parameter int unsigned DEPTH  = 6,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [15:0]       flush_ip,
  input  logic              bus_done,
  input  logic [DATA_W-1:0] bus_data,
  output logic              mem_read,
  output logic              inc_ip,
  output logic              load_ip,
  output logic [15:0]       ip_in,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  input  logic              q_pop,
  output logic [CNT_W-1:0]  q_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push_c;
  logic              pop_c;
  logic [PTR_W-1:0]  rd_next_c;
  logic [CNT_W-1:0]  cnt_next_c;
  logic [DATA_W-1:0] head_next_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Flush overrides both queue operations in the cycle it arrives.
  always_comb begin
    push_c      = (state == FETCH) && bus_done && !flush;
    pop_c       = q_pop && q_valid && !flush;
    rd_next_c   = pop_c ? ptr_inc(rd_ptr) : rd_ptr;
    cnt_next_c  = flush ? '0 : q_count + CNT_W'(push_c) - CNT_W'(pop_c);
    head_next_c = mem[rd_next_c];
    // A byte pushed into a queue that is empty after this cycle's pop becomes the head directly.
    if (push_c && ((q_count - CNT_W'(pop_c)) == '0))
      head_next_c = bus_data;
    if (cnt_next_c == '0)
      head_next_c = '0;
  end

  always_ff @(posedge clk) begin
    if (push_c)
      mem[wr_ptr] <= bus_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mem_read <= 1'b0;
      inc_ip   <= 1'b0;
      load_ip  <= 1'b0;
      ip_in    <= '0;
      q_valid  <= 1'b0;
      q_data   <= '0;
      q_count  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inc_ip  <= push_c;
      load_ip <= flush;
      if (flush)
        ip_in <= flush_ip;

      q_count <= cnt_next_c;
      q_valid <= (cnt_next_c != '0);
      q_data  <= head_next_c;

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_next_c;
        if (push_c)
          wr_ptr <= ptr_inc(wr_ptr);
      end

      // mem_read mirrors state membership in {FETCH, DRAIN}.
      case (state)
        IDLE: begin
          if (!flush && (q_count < CNT_W'(DEPTH))) begin
            state    <= FETCH;
            mem_read <= 1'b1;
          end
        end
        FETCH: begin
          if (bus_done) begin
            state    <= IDLE;
            mem_read <= 1'b0;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus_done) begin
            state    <= IDLE;
            mem_read <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          mem_read <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: reset, first fetch, fill, flush, ordered streaming,
// simultaneous push/pop/flush and asynchronous reset mid-fetch.
module tb_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] flush_ip;
  logic        bus_done;
  logic [7:0]  bus_data;
  logic        mem_read;
  logic        inc_ip;
  logic        load_ip;
  logic [15:0] ip_in;
  logic        q_valid;
  logic [7:0]  q_data;
  logic        q_pop;
  logic [3:0]  q_count;

  int checks;
  int errors;

  prefetch_queue #(.DEPTH(6), .DATA_W(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .flush_ip (flush_ip),
    .bus_done (bus_done),
    .bus_data (bus_data),
    .mem_read (mem_read),
    .inc_ip   (inc_ip),
    .load_ip  (load_ip),
    .ip_in    (ip_in),
    .q_valid  (q_valid),
    .q_data   (q_data),
    .q_pop    (q_pop),
    .q_count  (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a fetch request, then returns byte b for one cycle.
  task automatic fetch_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (mem_read !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL fetch_wait byte=%h mem_read=%b required=1", b, mem_read);
    end
    bus_done = 1'b1;
    bus_data = b;
    step();
    bus_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks += 7;
    if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read got=%b exp=0", mem_read); end
    if (inc_ip !== 1'b0)   begin errors++; $display("FAIL rst_inc_ip got=%b exp=0", inc_ip); end
    if (load_ip !== 1'b0)  begin errors++; $display("FAIL rst_load_ip got=%b exp=0", load_ip); end
    if (ip_in !== 16'h0)   begin errors++; $display("FAIL rst_ip_in got=%h exp=0000", ip_in); end
    if (q_valid !== 1'b0)  begin errors++; $display("FAIL rst_q_valid got=%b exp=0", q_valid); end
    if (q_data !== 8'h00)  begin errors++; $display("FAIL rst_q_data got=%h exp=00", q_data); end
    if (q_count !== 4'd0)  begin errors++; $display("FAIL rst_q_count got=%0d exp=0", q_count); end
  endtask

  task automatic test_first_fetch();
    rst = 1'b1;
    step();
    checks++;
    if (mem_read !== 1'b1) begin errors++; $display("FAIL t1_mem_read got=%b exp=1", mem_read); end
    bus_done = 1'b1;
    bus_data = 8'hB8;
    step();
    bus_done = 1'b0;
    checks += 5;
    if (q_valid !== 1'b1)  begin errors++; $display("FAIL t1_q_valid got=%b exp=1", q_valid); end
    if (q_data !== 8'hB8)  begin errors++; $display("FAIL t1_q_data got=%h exp=b8", q_data); end
    if (q_count !== 4'd1)  begin errors++; $display("FAIL t1_q_count got=%0d exp=1", q_count); end
    if (inc_ip !== 1'b1)   begin errors++; $display("FAIL t1_inc_ip got=%b exp=1", inc_ip); end
    if (mem_read !== 1'b0) begin errors++; $display("FAIL t1_mem_read_idle got=%b exp=0", mem_read); end
    step();
    checks++;
    if (inc_ip !== 1'b0) begin errors++; $display("FAIL t1_inc_ip_pulse got=%b exp=0", inc_ip); end
  endtask

  task automatic test_fill();
    // Consume B8 so the queue starts empty, then fill to DEPTH.
    q_pop = 1'b1;
    step();
    q_pop = 1'b0;
    checks++;
    if (q_count !== 4'd0) begin errors++; $display("FAIL t2_pop_b8 got=%0d exp=0", q_count); end
    for (int i = 1; i <= 6; i++) fetch_byte(8'(i));
    step();
    step();
    step();
    checks += 3;
    if (q_count !== 4'd6)  begin errors++; $display("FAIL t2_full_count got=%0d exp=6", q_count); end
    if (mem_read !== 1'b0) begin errors++; $display("FAIL t2_full_mem_read got=%b exp=0", mem_read); end
    if (q_data !== 8'h01)  begin errors++; $display("FAIL t2_full_head got=%h exp=01", q_data); end
    q_pop = 1'b1;
    step();
    q_pop = 1'b0;
    checks += 2;
    if (q_data !== 8'h02)  begin errors++; $display("FAIL t2_pop_head got=%h exp=02", q_data); end
    if (q_count !== 4'd5)  begin errors++; $display("FAIL t2_pop_count got=%0d exp=5", q_count); end
    step();
    checks++;
    if (mem_read !== 1'b1) begin errors++; $display("FAIL t2_refetch got=%b exp=1", mem_read); end
  endtask

  task automatic test_flush_fetch();
    flush    = 1'b1;
    flush_ip = 16'h0100;
    step();
    flush = 1'b0;
    checks += 5;
    if (q_count !== 4'd0)   begin errors++; $display("FAIL t4_count got=%0d exp=0", q_count); end
    if (q_valid !== 1'b0)   begin errors++; $display("FAIL t4_valid got=%b exp=0", q_valid); end
    if (load_ip !== 1'b1)   begin errors++; $display("FAIL t4_load_ip got=%b exp=1", load_ip); end
    if (ip_in !== 16'h0100) begin errors++; $display("FAIL t4_ip_in got=%h exp=0100", ip_in); end
    if (mem_read !== 1'b1)  begin errors++; $display("FAIL t4_drain_read got=%b exp=1", mem_read); end
    step();
    checks++;
    if (load_ip !== 1'b0) begin errors++; $display("FAIL t4_load_pulse got=%b exp=0", load_ip); end
    step();
    bus_done = 1'b1;
    bus_data = 8'hEE;
    step();
    bus_done = 1'b0;
    checks += 4;
    if (q_count !== 4'd0)  begin errors++; $display("FAIL t4_drop_count got=%0d exp=0", q_count); end
    if (q_valid !== 1'b0)  begin errors++; $display("FAIL t4_drop_valid got=%b exp=0", q_valid); end
    if (q_data === 8'hEE)  begin errors++; $display("FAIL t4_drop_data got=%h exp=not_ee", q_data); end
    if (inc_ip !== 1'b0)   begin errors++; $display("FAIL t4_no_inc got=%b exp=0", inc_ip); end
    step();
    checks += 3;
    if (inc_ip !== 1'b0)   begin errors++; $display("FAIL t4_no_inc_late got=%b exp=0", inc_ip); end
    if (q_valid !== 1'b0)  begin errors++; $display("FAIL t4_valid_late got=%b exp=0", q_valid); end
    if (mem_read !== 1'b1) begin errors++; $display("FAIL t4_resume got=%b exp=1", mem_read); end
  endtask

  task automatic test_order_wrap();
    int sent;
    int recv;
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 300 && recv < 20; cyc++) begin
      bus_done = (mem_read === 1'b1) && (sent < 20);
      bus_data = 8'(sent);
      if (bus_done) sent++;
      q_pop = ((cyc % 2) == 1) && (q_valid === 1'b1);
      if (q_pop) begin
        checks++;
        if (q_data !== 8'(recv)) begin
          errors++;
          $display("FAIL t3_order idx=%0d got=%h exp=%h", recv, q_data, 8'(recv));
        end
        recv++;
      end
      step();
    end
    bus_done = 1'b0;
    q_pop    = 1'b0;
    checks += 2;
    if (recv != 20)       begin errors++; $display("FAIL t3_count got=%0d exp=20", recv); end
    if (q_count !== 4'd0) begin errors++; $display("FAIL t3_empty got=%0d exp=0", q_count); end
  endtask

  task automatic test_simultaneous();
    fetch_byte(8'hA1);
    fetch_byte(8'hA2);
    fetch_byte(8'hA3);
    step();
    bus_done = 1'b1;
    bus_data = 8'hA4;
    q_pop    = 1'b1;
    step();
    bus_done = 1'b0;
    q_pop    = 1'b0;
    checks += 2;
    if (q_count !== 4'd3) begin errors++; $display("FAIL t5_pushpop_count got=%0d exp=3", q_count); end
    if (q_data !== 8'hA2) begin errors++; $display("FAIL t5_pushpop_head got=%h exp=a2", q_data); end
    q_pop = 1'b1;
    step();
    q_pop = 1'b0;
    checks++;
    if (q_count !== 4'd2) begin errors++; $display("FAIL t5_pop_count got=%0d exp=2", q_count); end
    flush    = 1'b1;
    flush_ip = 16'h2345;
    q_pop    = 1'b1;
    step();
    flush = 1'b0;
    q_pop = 1'b0;
    checks += 4;
    if (q_count !== 4'd0)   begin errors++; $display("FAIL t5_flushpop_count got=%0d exp=0", q_count); end
    if (q_valid !== 1'b0)   begin errors++; $display("FAIL t5_flushpop_valid got=%b exp=0", q_valid); end
    if (load_ip !== 1'b1)   begin errors++; $display("FAIL t5_load_ip got=%b exp=1", load_ip); end
    if (ip_in !== 16'h2345) begin errors++; $display("FAIL t5_ip_in got=%h exp=2345", ip_in); end
    bus_done = 1'b1;
    bus_data = 8'h55;
    step();
    bus_done = 1'b0;
    q_pop = 1'b1;
    step();
    q_pop = 1'b0;
    checks += 2;
    if (q_count !== 4'd0) begin errors++; $display("FAIL t5_empty_pop_count got=%0d exp=0", q_count); end
    if (q_valid !== 1'b0) begin errors++; $display("FAIL t5_empty_pop_valid got=%b exp=0", q_valid); end
  endtask

  task automatic test_reset_mid();
    fetch_byte(8'hC1);
    fetch_byte(8'hC2);
    fetch_byte(8'hC3);
    fetch_byte(8'hC4);
    step();
    checks += 2;
    if (q_count !== 4'd4)  begin errors++; $display("FAIL t6_pre_count got=%0d exp=4", q_count); end
    if (mem_read !== 1'b1) begin errors++; $display("FAIL t6_pre_read got=%b exp=1", mem_read); end
    rst = 1'b0;
    #2;
    checks += 6;
    if (q_count !== 4'd0)  begin errors++; $display("FAIL t6_count got=%0d exp=0", q_count); end
    if (q_valid !== 1'b0)  begin errors++; $display("FAIL t6_valid got=%b exp=0", q_valid); end
    if (q_data !== 8'h00)  begin errors++; $display("FAIL t6_data got=%h exp=00", q_data); end
    if (mem_read !== 1'b0) begin errors++; $display("FAIL t6_mem_read got=%b exp=0", mem_read); end
    if (ip_in !== 16'h0)   begin errors++; $display("FAIL t6_ip_in got=%h exp=0000", ip_in); end
    if (inc_ip !== 1'b0 || load_ip !== 1'b0) begin
      errors++;
      $display("FAIL t6_pulses got=%b%b exp=00", inc_ip, load_ip);
    end
    step();
    rst      = 1'b1;
    bus_done = 1'b1;
    bus_data = 8'h77;
    step();
    bus_done = 1'b0;
    checks += 3;
    if (q_count !== 4'd0) begin errors++; $display("FAIL t6_late_done_count got=%0d exp=0", q_count); end
    if (q_valid !== 1'b0) begin errors++; $display("FAIL t6_late_done_valid got=%b exp=0", q_valid); end
    if (inc_ip !== 1'b0)  begin errors++; $display("FAIL t6_late_done_inc got=%b exp=0", inc_ip); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    flush    = 1'b0;
    flush_ip = 16'h0;
    bus_done = 1'b0;
    bus_data = 8'h00;
    q_pop    = 1'b0;
    test_reset();
    test_first_fetch();
    test_fill();
    test_flush_fetch();
    test_order_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule
